trap_ctrl: RTL and testbench

Trap sequencing controller for the machine-mode CSR/interrupt datapath. It arbitrates between synchronous exceptions, the three machine interrupt sources and mret. It freezes and flushes the pipeline, waits for outstanding memory traffic to drain, then issues a single trap-entry or trap-return command to the CSR unit and redirects fetch. It sits between EX/LSU and the CSR register block.

---
 rtl/trap_ctrl_pkg.sv | 20 ++
 rtl/trap_prio.sv | 36 +++
 rtl/trap_ctrl.sv | 144 ++++++++++++++
 tb/tb_trap_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states, interrupt
// cause codes and mtvec mode encodings.
package trap_ctrl_pkg;

    typedef enum logic [2:0] {
        TRAP_IDLE,
        TRAP_FLUSH,
        TRAP_DRAIN,
        TRAP_ENTER,
        TRAP_RET
    } trap_state_e;

    localparam logic [3:0] IRQ_MEI = 4'd11;
    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_prio.sv
// Combinational priority encoder for the three machine interrupt sources
// (external > software > timer), gated by the per-source and global enables.
module trap_prio
    import trap_ctrl_pkg::*;
(
    input  logic       ext_irq_i,
    input  logic       sft_irq_i,
    input  logic       tmr_irq_i,
    input  logic       meie_i,
    input  logic       msie_i,
    input  logic       mtie_i,
    input  logic       glb_irq_i,
    output logic       take_o,
    output logic [3:0] code_o
);

    logic ext_en;
    logic sft_en;
    logic tmr_en;

    always_comb begin
        ext_en = ext_irq_i & meie_i;
        sft_en = sft_irq_i & msie_i;
        tmr_en = tmr_irq_i & mtie_i;
        take_o = glb_irq_i & (ext_en | sft_en | tmr_en);
        code_o = 4'd0;
        if (ext_en) begin
            code_o = IRQ_MEI;
        end else if (sft_en) begin
            code_o = IRQ_MSI;
        end else if (tmr_en) begin
            code_o = IRQ_MTI;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: freezes/flushes the pipeline, drains the LSU, then issues one
// trap-entry or trap-return command to the CSR block and redirects fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ext_irq_i,
    input  logic               sft_irq_i,
    input  logic               tmr_irq_i,
    input  logic               meie_i,
    input  logic               msie_i,
    input  logic               mtie_i,
    input  logic               glb_irq_i,
    input  logic               exp_vld_i,
    input  logic [CAUSE_W-1:0] exp_cause_i,
    input  logic [XLEN-1:0]    exp_pc_i,
    input  logic [XLEN-1:0]    exp_tval_i,
    input  logic               ex_vld_i,
    input  logic [XLEN-1:0]    ex_pc_i,
    input  logic               mret_i,
    input  logic               lsu_busy_i,
    input  logic [XLEN-1:0]    mtvec_i,
    input  logic [XLEN-1:0]    mepc_i,
    output logic               hold_o,
    output logic               flush_o,
    output logic               trap_wr_o,
    output logic               mret_wr_o,
    output logic [XLEN-1:0]    mepc_o,
    output logic [XLEN-1:0]    mcause_o,
    output logic [XLEN-1:0]    mtval_o,
    output logic               redir_vld_o,
    output logic [XLEN-1:0]    redir_pc_o
);

    trap_state_e     state_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] tval_q;

    logic            irq_pend;
    logic            irq_take;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] irq_cause;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    trap_prio u_prio (
        .ext_irq_i (ext_irq_i),
        .sft_irq_i (sft_irq_i),
        .tmr_irq_i (tmr_irq_i),
        .meie_i    (meie_i),
        .msie_i    (msie_i),
        .mtie_i    (mtie_i),
        .glb_irq_i (glb_irq_i),
        .take_o    (irq_pend),
        .code_o    (irq_code)
    );

    // Interrupts are only taken against a real EX instruction so mepc is meaningful.
    always_comb begin
        irq_take            = irq_pend & ex_vld_i;
        irq_cause           = '0;
        irq_cause[3:0]      = irq_code;
        irq_cause[XLEN-1]   = 1'b1;
        trap_base           = {mtvec_i[XLEN-1:2], 2'b00};
        trap_target         = trap_base;
        if (mtvec_i[1:0] == MTVEC_VECTORED && cause_q[XLEN-1]) begin
            trap_target = trap_base + XLEN'({cause_q[3:0], 2'b00});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= TRAP_IDLE;
            cause_q     <= '0;
            epc_q       <= '0;
            tval_q      <= '0;
            hold_o      <= 1'b0;
            flush_o     <= 1'b0;
            trap_wr_o   <= 1'b0;
            mret_wr_o   <= 1'b0;
            redir_vld_o <= 1'b0;
            redir_pc_o  <= '0;
            mepc_o      <= '0;
            mcause_o    <= '0;
            mtval_o     <= '0;
        end else begin
            hold_o      <= 1'b0;
            flush_o     <= 1'b0;
            trap_wr_o   <= 1'b0;
            mret_wr_o   <= 1'b0;
            redir_vld_o <= 1'b0;
            redir_pc_o  <= '0;
            mepc_o      <= '0;
            mcause_o    <= '0;
            mtval_o     <= '0;
            case (state_q)
                TRAP_IDLE: begin
                    if (exp_vld_i) begin
                        state_q <= TRAP_FLUSH;
                        cause_q <= XLEN'(exp_cause_i);
                        epc_q   <= exp_pc_i;
                        tval_q  <= exp_tval_i;
                        flush_o <= 1'b1;
                        hold_o  <= 1'b1;
                    end else if (irq_take) begin
                        state_q <= TRAP_FLUSH;
                        cause_q <= irq_cause;
                        epc_q   <= ex_pc_i;
                        tval_q  <= '0;
                        flush_o <= 1'b1;
                        hold_o  <= 1'b1;
                    end else if (mret_i) begin
                        state_q     <= TRAP_RET;
                        flush_o     <= 1'b1;
                        mret_wr_o   <= 1'b1;
                        redir_vld_o <= 1'b1;
                        redir_pc_o  <= {mepc_i[XLEN-1:1], 1'b0};
                    end
                end
                TRAP_FLUSH, TRAP_DRAIN: begin
                    hold_o <= 1'b1;
                    if (!lsu_busy_i) begin
                        state_q     <= TRAP_ENTER;
                        trap_wr_o   <= 1'b1;
                        redir_vld_o <= 1'b1;
                        redir_pc_o  <= trap_target;
                        mepc_o      <= epc_q;
                        mcause_o    <= cause_q;
                        mtval_o     <= tval_q;
                    end else begin
                        state_q <= TRAP_DRAIN;
                    end
                end
                default: state_q <= TRAP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned CAUSE_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               ext_irq_i, sft_irq_i, tmr_irq_i;
    logic               meie_i, msie_i, mtie_i, glb_irq_i;
    logic               exp_vld_i;
    logic [CAUSE_W-1:0] exp_cause_i;
    logic [XLEN-1:0]    exp_pc_i, exp_tval_i;
    logic               ex_vld_i;
    logic [XLEN-1:0]    ex_pc_i;
    logic               mret_i, lsu_busy_i;
    logic [XLEN-1:0]    mtvec_i, mepc_i;
    logic               hold_o, flush_o, trap_wr_o, mret_wr_o, redir_vld_o;
    logic [XLEN-1:0]    mepc_o, mcause_o, mtval_o, redir_pc_o;

    int checks   = 0;
    int failures = 0;
    int flush_cnt;

    trap_ctrl #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .ext_irq_i   (ext_irq_i),
        .sft_irq_i   (sft_irq_i),
        .tmr_irq_i   (tmr_irq_i),
        .meie_i      (meie_i),
        .msie_i      (msie_i),
        .mtie_i      (mtie_i),
        .glb_irq_i   (glb_irq_i),
        .exp_vld_i   (exp_vld_i),
        .exp_cause_i (exp_cause_i),
        .exp_pc_i    (exp_pc_i),
        .exp_tval_i  (exp_tval_i),
        .ex_vld_i    (ex_vld_i),
        .ex_pc_i     (ex_pc_i),
        .mret_i      (mret_i),
        .lsu_busy_i  (lsu_busy_i),
        .mtvec_i     (mtvec_i),
        .mepc_i      (mepc_i),
        .hold_o      (hold_o),
        .flush_o     (flush_o),
        .trap_wr_o   (trap_wr_o),
        .mret_wr_o   (mret_wr_o),
        .mepc_o      (mepc_o),
        .mcause_o    (mcause_o),
        .mtval_o     (mtval_o),
        .redir_vld_o (redir_vld_o),
        .redir_pc_o  (redir_pc_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (flush_o) flush_cnt++;
    endtask

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packs the five control strobes: {hold, flush, trap_wr, mret_wr, redir_vld}
    function automatic logic [XLEN-1:0] ctl();
        return XLEN'({hold_o, flush_o, trap_wr_o, mret_wr_o, redir_vld_o});
    endfunction

    initial begin
        rst = 1'b1;
        {ext_irq_i, sft_irq_i, tmr_irq_i, meie_i, msie_i, mtie_i, glb_irq_i} = '0;
        exp_vld_i = 0; exp_cause_i = '0; exp_pc_i = '0; exp_tval_i = '0;
        ex_vld_i = 0; ex_pc_i = '0; mret_i = 0; lsu_busy_i = 0;
        mtvec_i = '0; mepc_i = '0; flush_cnt = 0;

        step(); step();
        check("reset_ctl", ctl(), 64'h0);
        check("reset_mcause", mcause_o, 64'h0);
        check("reset_redir_pc", redir_pc_o, 64'h0);
        rst = 1'b0;
        step();
        check("idle_ctl", ctl(), 64'h0);

        // Exception, direct mtvec, LSU idle
        exp_vld_i = 1; exp_cause_i = 4'd2; exp_pc_i = 64'h8000_0010;
        exp_tval_i = 64'hDEAD_BEEF; mtvec_i = 64'h8000_0100;
        step();
        exp_vld_i = 0;
        check("exc_flush_ctl", ctl(), 64'b11000);
        step();
        check("exc_enter_ctl", ctl(), 64'b10101);
        check("exc_mcause", mcause_o, 64'h2);
        check("exc_mepc", mepc_o, 64'h8000_0010);
        check("exc_mtval", mtval_o, 64'hDEAD_BEEF);
        check("exc_redir", redir_pc_o, 64'h8000_0100);
        step();
        check("exc_back_idle", ctl(), 64'h0);

        // Vectored timer interrupt
        tmr_irq_i = 1; mtie_i = 1; glb_irq_i = 1; ex_vld_i = 1;
        ex_pc_i = 64'h200; mtvec_i = 64'h1001;
        step();
        tmr_irq_i = 0;
        check("tmr_flush_ctl", ctl(), 64'b11000);
        step();
        check("tmr_enter_ctl", ctl(), 64'b10101);
        check("tmr_mcause", mcause_o, 64'h8000_0000_0000_0007);
        check("tmr_mepc", mepc_o, 64'h200);
        check("tmr_mtval", mtval_o, 64'h0);
        check("tmr_redir", redir_pc_o, 64'h101C);
        step();

        // All interrupts plus an exception: exception wins; irqs held but ignored mid-sequence
        ext_irq_i = 1; sft_irq_i = 1; tmr_irq_i = 1; meie_i = 1; msie_i = 1; mtie_i = 1;
        exp_vld_i = 1; exp_cause_i = 4'd5; exp_pc_i = 64'h300; exp_tval_i = 64'h44;
        step();
        exp_vld_i = 0;
        step();
        check("prio_exc_mcause", mcause_o, 64'h5);
        check("prio_exc_mepc", mepc_o, 64'h300);
        ext_irq_i = 0; sft_irq_i = 0; tmr_irq_i = 0;
        step();
        check("prio_exc_idle", ctl(), 64'h0);

        // All interrupts, no exception: external (11) wins, vectored
        ext_irq_i = 1; sft_irq_i = 1; tmr_irq_i = 1; ex_pc_i = 64'h400;
        step();
        ext_irq_i = 0; sft_irq_i = 0; tmr_irq_i = 0;
        step();
        check("prio_irq_mcause", mcause_o, 64'h8000_0000_0000_000B);
        check("prio_irq_mepc", mepc_o, 64'h400);
        check("prio_irq_redir", redir_pc_o, 64'h102C);
        step();

        // Drain: LSU busy for three cycles
        flush_cnt = 0;
        exp_vld_i = 1; exp_cause_i = 4'd1; exp_pc_i = 64'h500; exp_tval_i = '0;
        mtvec_i = 64'h8000_0100; lsu_busy_i = 1;
        step();
        exp_vld_i = 0;
        check("drain_flush_ctl", ctl(), 64'b11000);
        step();
        check("drain_c1_ctl", ctl(), 64'b10000);
        step();
        check("drain_c2_ctl", ctl(), 64'b10000);
        lsu_busy_i = 0;
        step();
        check("drain_enter_ctl", ctl(), 64'b10101);
        check("drain_mcause", mcause_o, 64'h1);
        step();
        check("drain_idle_ctl", ctl(), 64'h0);
        check("drain_flush_count", XLEN'(flush_cnt), 64'd1);

        // mret with masked pending irq
        glb_irq_i = 0; tmr_irq_i = 1; mtie_i = 1; ex_vld_i = 1;
        mret_i = 1; mepc_i = 64'h8000_0043;
        step();
        mret_i = 0;
        check("mret_ctl", ctl(), 64'b01011);
        check("mret_redir", redir_pc_o, 64'h8000_0042);
        step();
        check("mret_idle_ctl", ctl(), 64'h0);
        step();
        check("masked_irq_ctl", ctl(), 64'h0);

        // Bubble: enabled irq but no valid EX instruction
        glb_irq_i = 1; ex_vld_i = 0;
        step();
        check("bubble_ctl", ctl(), 64'h0);
        ex_vld_i = 1; ex_pc_i = 64'h600;
        step();
        tmr_irq_i = 0;
        check("bubble_then_take", ctl(), 64'b11000);
        step(); step();
        check("bubble_done_idle", ctl(), 64'h0);

        // Reset in the middle of DRAIN cancels the trap
        exp_vld_i = 1; exp_cause_i = 4'd4; exp_pc_i = 64'h700; lsu_busy_i = 1;
        step();
        exp_vld_i = 0;
        step();
        check("rst_pre_drain", ctl(), 64'b10000);
        rst = 1;
        step();
        check("rst_mid_ctl", ctl(), 64'h0);
        check("rst_mid_mcause", mcause_o, 64'h0);
        rst = 0; lsu_busy_i = 0;
        step();
        check("rst_after_ctl", ctl(), 64'h0);
        step();
        check("rst_after2_ctl", ctl(), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
